operand_collector: RTL and testbench
====================================

// Module: operand_collector
// PURPOSE
//  Single-entry operand collector feeding the execution stage from the vector register file.
//  Accepts one issued instruction carrying up to three 8-bit source register addresses.
//  Reads each enabled source through the register file's single 1-cycle-latency read port.
//  Merges same-cycle writeback lanes, then presents all operands together on a valid/ready output.
// PARAMETERS
//  ADDR_W  8    register address width (256 entries)
//  DATA_W  256  register width
//  LANES   8    write-mask lanes; lane width = DATA_W/LANES = 32
//  TAG_W   8    opaque instruction tag carried through unchanged
// PORTS
//  clock      in   1       single clock, all state on posedge
//  reset      in   1       synchronous, active-high
//  in_valid   in   1       issue request
//  in_ready   out  1       collector can accept
//  in_rs_en   in   3       bit i: source i+1 is needed
//  in_rs1/2/3 in   ADDR_W  source register addresses
//  in_tag     in   TAG_W   instruction tag
//  rf_en      out  1       register file read enable
//  rf_addr    out  ADDR_W  register file read address
//  rf_data    in   DATA_W  read data, valid the cycle after rf_en
//  wb_en      in   1       writeback in progress (same signals drive the register file write port)
//  wb_addr    in   ADDR_W  writeback address
//  wb_data    in   DATA_W  writeback data
//  wb_mask    in   LANES   writeback lane mask
//  out_valid  out  1       operands complete
//  out_ready  in   1       execution stage accepts
//  out_op1/2/3 out DATA_W  collected operands; zero when the source is not enabled
//  out_tag    out  TAG_W   tag of the collected instruction
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; in_ready=1; rf_en=0; rf_addr=0; out_valid=0; out_op*=0; out_tag=0.
//  States: IDLE, READ, DRAIN, OUT.
//  IDLE:
//   - in_ready=1.
//   - On in_valid: latch the addresses, in_rs_en and in_tag; clear all operand registers to 0.
//   - Next state is READ if any in_rs_en bit is set, otherwise OUT.
//  READ:
//   - Each cycle assert rf_en with the address of the lowest-numbered enabled source not yet read.
//   - Exactly one read per cycle; sources are read in order 1, 2, 3 with disabled sources skipped.
//   - After issuing the last enabled source, go to DRAIN.
//  Capture:
//   - In the cycle after each rf_en, register rf_data into that source's operand register.
//   - This applies in READ and in DRAIN.
//  Bypass:
//   - In a capture cycle, if wb_en and wb_addr equals the captured source address, then for every
//     lane l with wb_mask[l]=1 the captured lane is taken from wb_data instead of rf_data.
//   - Reason: that write lands in the RAM only after capture.
//   - Writes in the rf_en cycle itself are already visible in rf_data and are not bypassed.
//   - Writes after capture are ignored; hazard avoidance there is the scoreboard's job.
//  DRAIN:
//   - Lasts one cycle; the last source is captured. Next state is OUT.
//  OUT:
//   - out_valid=1.
//   - out_op*/out_tag stay stable until out_valid && out_ready, then go to IDLE.
//  Latency:
//   - N enabled sources (N>=1): out_valid rises N+2 cycles after the accept edge.
//   - N=0: out_valid rises 1 cycle after the accept edge.
//  in_ready=0 in READ, DRAIN and OUT. No new accept in the same cycle as the out handshake.
//  Duplicate source addresses are read separately; each capture gets its own bypass check.
//  Reset mid-operation:
//   - Return to IDLE with all outputs at reset values.
//   - rf_data returning in the cycle after reset is ignored.
// TESTING
//  1. rs_en=3'b111, rs=5/6/7, RAM[r]=r pattern, out_ready=1 -> rf_addr 5,6,7 on cycles 1-3; out_valid at cycle 5 with matching ops.
//  2. rs_en=3'b101, rs1=10, rs3=20 -> reads 10 then 20 only; out_op2=0; out_valid at cycle 4.
//  3. rs_en=0, tag=8'hA5 -> out_valid at cycle 1, all ops 0, out_tag=A5, no rf_en pulses.
//  4. rs_en=3'b001, rs1=3; capture-cycle wb_en, wb_addr=3, mask=8'h0F -> lanes 0-3 = wb_data, lanes 4-7 = old RAM.
//  5. out_ready held 0 for 4 cycles in OUT -> ops/tag stable, in_ready=0; on release, in_ready=1 the next cycle.
//  6. reset asserted in the cycle after the 2nd rf_en -> next cycle IDLE, out_valid=0, ops 0; new issue completes normally.

Source files
------------

// File: rtl/operand_collector.sv
// -----------------------------------------------------------------------------
// operand_collector
//   Single-entry operand collector between issue and the execution stage.
//   Takes one instruction with up to three source register addresses, reads
//   each enabled source through the register file's single 1-cycle-latency
//   read port, merges same-cycle writeback lanes at capture time, and presents
//   all operands together on a valid/ready output.
//
// Ports
//   clock, reset          clock; synchronous active-high reset
//   in_valid / in_ready   issue handshake
//   in_rs_en              bit i set: source i+1 is needed
//   in_rs1/2/3, in_tag    source addresses and opaque tag
//   rf_en, rf_addr        register file read request
//   rf_data               read data, valid the cycle after rf_en
//   wb_en/addr/data/mask  writeback port (also drives the register file)
//   out_valid / out_ready result handshake
//   out_op1/2/3, out_tag  collected operands (zero for disabled sources)
// -----------------------------------------------------------------------------
module operand_collector #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 256,
    parameter int LANES  = 8,
    parameter int TAG_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_rs_en,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rs3,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              rf_en,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [LANES-1:0]  wb_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [DATA_W-1:0] out_op3,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int LANE_W = DATA_W / LANES;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_OUT} state_t;

    state_t            state, state_nxt;
    logic [2:0]        pend_q, pend_nxt;      // enabled sources not yet read
    logic [1:0]        sel_idx;               // source being read this cycle
    logic [ADDR_W-1:0] src1_q, src2_q, src3_q;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] op1_q, op2_q, op3_q;
    logic              cap_pend_q;            // rf_data this cycle belongs to us
    logic [1:0]        cap_idx_q;
    logic [ADDR_W-1:0] cap_addr_q;
    logic [DATA_W-1:0] cap_data;
    logic              accept;

    assign accept    = (state == S_IDLE) && in_valid;
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_OUT);
    assign out_op1   = op1_q;
    assign out_op2   = op2_q;
    assign out_op3   = op3_q;
    assign out_tag   = tag_q;

    // Lowest-numbered pending source wins; disabled sources never enter pend_q.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        sel_idx = 2'd0;
        if (pend_q[0])      sel_idx = 2'd0;
        else if (pend_q[1]) sel_idx = 2'd1;
        else if (pend_q[2]) sel_idx = 2'd2;
    end

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend_q;
        rf_en     = 1'b0;
        rf_addr   = '0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    pend_nxt  = in_rs_en;
                    state_nxt = (|in_rs_en) ? S_READ : S_OUT;
                end
            end
            S_READ: begin
                rf_en = 1'b1;
                case (sel_idx)
                    2'd0:    rf_addr = src1_q;
                    2'd1:    rf_addr = src2_q;
                    default: rf_addr = src3_q;
                endcase
                pend_nxt = pend_q & ~(3'b001 << sel_idx);
                if (pend_nxt == 3'b000) state_nxt = S_DRAIN;
            end
            S_DRAIN: state_nxt = S_OUT;
            S_OUT:   if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A write landing in the capture cycle reaches the RAM only after this
    // capture, so its masked lanes are forwarded here. Writes during the
    // rf_en cycle are already reflected in rf_data.
    always_comb begin
        cap_data = rf_data;
        if (wb_en && (wb_addr == cap_addr_q)) begin
            for (int l = 0; l < LANES; l++) begin
                if (wb_mask[l]) cap_data[l*LANE_W +: LANE_W] = wb_data[l*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (reset) begin
            state  <= S_IDLE;
            pend_q <= '0;
        end else begin
            state  <= state_nxt;
            pend_q <= pend_nxt;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: the wide operand registers are reset because they drive the
        // outputs directly and must read zero after reset; clearing
        // cap_pend_q also drops any read still in flight across reset.
        if (reset) begin
            src1_q     <= '0;
            src2_q     <= '0;
            src3_q     <= '0;
            tag_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            op3_q      <= '0;
            cap_pend_q <= 1'b0;
            cap_idx_q  <= 2'd0;
            cap_addr_q <= '0;
        end else begin
            cap_pend_q <= rf_en;
            cap_idx_q  <= sel_idx;
            cap_addr_q <= rf_addr;
            if (accept) begin
                src1_q <= in_rs1;
                src2_q <= in_rs2;
                src3_q <= in_rs3;
                tag_q  <= in_tag;
                op1_q  <= '0;
                op2_q  <= '0;
                op3_q  <= '0;
            end else if (cap_pend_q) begin
                case (cap_idx_q)
                    2'd0:    op1_q <= cap_data;
                    2'd1:    op2_q <= cap_data;
                    default: op3_q <= cap_data;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_operand_collector.sv
module tb_operand_collector;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 256;
    localparam int LANES  = 8;
    localparam int TAG_W  = 8;
    localparam int LANE_W = DATA_W / LANES;

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_rs_en;
    logic [ADDR_W-1:0] in_rs1, in_rs2, in_rs3;
    logic [TAG_W-1:0]  in_tag;
    logic              rf_en;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [LANES-1:0]  wb_mask;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_op1, out_op2, out_op3;
    logic [TAG_W-1:0]  out_tag;

    operand_collector #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES), .TAG_W(TAG_W)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_rs_en(in_rs_en),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3), .in_tag(in_tag),
        .rf_en(rf_en), .rf_addr(rf_addr), .rf_data(rf_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_mask(wb_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_op3(out_op3), .out_tag(out_tag)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [DATA_W-1:0] op3;
    } exp_t;

    exp_t              sb_q[$];
    int                checks   = 0;
    int                failures = 0;
    logic [DATA_W-1:0] ram [256];

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                                input logic [DATA_W-1:0] new_v,
                                                input logic [LANES-1:0] mask);
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int l = 0; l < LANES; l++)
            if (mask[l]) r[l*LANE_W +: LANE_W] = new_v[l*LANE_W +: LANE_W];
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] pat(input int r);
        logic [DATA_W-1:0] v;
        for (int l = 0; l < LANES; l++)
            v[l*LANE_W +: LANE_W] = {8'(r), 8'(l), ~8'(r), 8'h5A};
        return v;
    endfunction

    // Register file model: write-first, registered read.
    always @(posedge clock) begin
        if (wb_en) ram[wb_addr] = merge(ram[wb_addr], wb_data, wb_mask);
        if (rf_en) rf_data <= ram[rf_addr];
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one instruction and follow it cycle by cycle to the output
    // handshake. wb_cyc (0 = none) is the cycle after the accept edge in
    // which one writeback is driven; hold is the number of OUT cycles with
    // out_ready low. Called at a negedge with the collector idle.
    task automatic run_op(input logic [2:0] en, input logic [7:0] a1, input logic [7:0] a2,
                          input logic [7:0] a3, input logic [7:0] tag, input int wb_cyc,
                          input logic [7:0] wa, input logic [DATA_W-1:0] wd,
                          input logic [7:0] wm, input int hold);
        logic [7:0]        addrs [3];
        logic [DATA_W-1:0] v [3];
        logic [7:0]        rd [$];
        exp_t              e;
        int                n, last;
        addrs = '{a1, a2, a3};
        n = 0;
        for (int i = 0; i < 3; i++) begin
            v[i] = '0;
            if (en[i]) begin
                n++;
                v[i] = ram[addrs[i]];
                // The write counts if it lands no later than this source's capture cycle.
                if (wb_cyc >= 1 && wb_cyc <= n + 1 && wa == addrs[i]) v[i] = merge(v[i], wd, wm);
                rd.push_back(addrs[i]);
            end
        end
        e.tag = tag; e.op1 = v[0]; e.op2 = v[1]; e.op3 = v[2];
        sb_q.push_back(e);
        last = (n == 0) ? 1 : n + 2;

        check("in_ready_idle", 256'(in_ready), 256'(1));
        in_valid = 1'b1; in_rs_en = en; in_rs1 = a1; in_rs2 = a2; in_rs3 = a3; in_tag = tag;
        @(negedge clock);
        in_valid = 1'b0; in_rs_en = 3'($urandom); in_tag = 8'($urandom);
        for (int c = 1; c <= last; c++) begin
            if (c <= n) begin
                check("rf_en_read", 256'(rf_en), 256'(1));
                check("rf_addr", 256'(rf_addr), 256'(rd[c-1]));
            end else begin
                check("rf_en_quiet", 256'(rf_en), 256'(0));
            end
            check("in_ready_busy", 256'(in_ready), 256'(0));
            check(c < last ? "out_valid_early" : "out_valid_latency",
                  256'(out_valid), 256'(c == last));
            wb_en = (c == wb_cyc); wb_addr = wa; wb_data = wd; wb_mask = wm;
            if (c < last) @(negedge clock);
        end
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            check("hold_valid", 256'(out_valid), 256'(1));
            check("hold_in_ready", 256'(in_ready), 256'(0));
            check("hold_op1", out_op1, sb_q[0].op1);
            check("hold_tag", 256'(out_tag), 256'(sb_q[0].tag));
            @(negedge clock);
            wb_en = 1'b0;
        end
        out_ready = 1'b1;
        e = sb_q.pop_front();
        check("out_op1", out_op1, e.op1);
        check("out_op2", out_op2, e.op2);
        check("out_op3", out_op3, e.op3);
        check("out_tag", 256'(out_tag), 256'(e.tag));
        @(negedge clock);
        wb_en = 1'b0;
        check("out_valid_drop", 256'(out_valid), 256'(0));
        check("in_ready_back", 256'(in_ready), 256'(1));
    endtask

    initial begin
        logic [DATA_W-1:0] wd_a, wd_b, wd_c;
        for (int r = 0; r < 256; r++) ram[r] = pat(r);
        rf_data = '0;
        reset = 1'b1; in_valid = 1'b0; in_rs_en = '0; in_rs1 = '0; in_rs2 = '0; in_rs3 = '0;
        in_tag = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0; wb_mask = '0; out_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_in_ready", 256'(in_ready), 256'(1));
        check("rst_rf_en", 256'(rf_en), 256'(0));
        check("rst_rf_addr", 256'(rf_addr), 256'(0));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_op1", out_op1, '0);
        check("rst_tag", 256'(out_tag), 256'(0));
        reset = 1'b0;
        @(negedge clock);

        wd_a = {8{32'hDEAD_0000}} ^ {LANES{32'h0000_1111}};
        wd_b = {8{32'hCAFE_F00D}};
        wd_c = {8{32'h1234_5678}};

        run_op(3'b111, 8'd5, 8'd6, 8'd7, 8'h11, 0, 8'd0, '0, 8'h00, 0);     // all three sources
        run_op(3'b101, 8'd10, 8'd33, 8'd20, 8'h22, 0, 8'd0, '0, 8'h00, 0);  // skip source 2
        run_op(3'b000, 8'd1, 8'd2, 8'd3, 8'hA5, 0, 8'd0, '0, 8'h00, 0);     // nothing to read
        run_op(3'b001, 8'd3, 8'd0, 8'd0, 8'h44, 2, 8'd3, wd_a, 8'h0F, 0);   // bypass lanes 0-3
        run_op(3'b001, 8'd3, 8'd0, 8'd0, 8'h45, 3, 8'd3, wd_b, 8'hFF, 0);   // write after capture
        run_op(3'b111, 8'd9, 8'd9, 8'd9, 8'h46, 3, 8'd9, wd_c, 8'hF0, 0);   // duplicate sources
        run_op(3'b110, 8'd40, 8'd41, 8'd42, 8'h55, 0, 8'd0, '0, 8'h00, 4); // backpressure
        run_op(3'b010, 8'd0, 8'd200, 8'd0, 8'h56, 1, 8'd200, wd_b, 8'h81, 0); // write in rf_en cycle

        // Reset in the cycle after the second read request.
        check("mid_in_ready", 256'(in_ready), 256'(1));
        in_valid = 1'b1; in_rs_en = 3'b111; in_rs1 = 8'd5; in_rs2 = 8'd6; in_rs3 = 8'd7;
        in_tag = 8'h66;
        @(negedge clock);
        in_valid = 1'b0;
        check("mid_rf_addr1", 256'(rf_addr), 256'(5));
        @(negedge clock);
        check("mid_rf_addr2", 256'(rf_addr), 256'(6));
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_valid", 256'(out_valid), 256'(0));
        check("mid_rst_in_ready", 256'(in_ready), 256'(1));
        check("mid_rst_rf_en", 256'(rf_en), 256'(0));
        check("mid_rst_op1", out_op1, '0);
        check("mid_rst_op2", out_op2, '0);
        check("mid_rst_tag", 256'(out_tag), 256'(0));
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_op3", out_op3, '0);
        check("post_rst_valid", 256'(out_valid), 256'(0));
        run_op(3'b011, 8'd77, 8'd78, 8'd0, 8'h67, 0, 8'd0, '0, 8'h00, 0);

        check("sb_empty", 256'(sb_q.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
